// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; depth must be a power of two.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Full/empty come from the count, so pointers simply wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frames, programmable bit period, parity, 1/2 stop bits.
// Optional break generation (send_break port) enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        PAR_EN,
    input  logic                        PAR_TYP,
    input  logic                        STOP2,
    input  logic [PRESCALE_W-1:0]       Prescale,
    input  logic [DATA_WIDTH-1:0]       P_DATA,
    input  logic                        data_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                        send_break,
`endif
    output logic                        ready,
    output logic                        TX_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    tx_state_e              state_q, state_d;
    logic [PRESCALE_W-1:0]  timer_q, timer_d, prescale_q, period_m1;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d, head;
    logic                   stop_idx_q, stop_idx_d;
    logic                   tx_q, tx_d, busy_q, busy_d;
    logic                   par_q, par_en_q, stop2_q;
    logic                   fifo_full, fifo_empty, pop, cfg_ld, frame_done, bit_end;
`ifdef UART_TX_BREAK_EN
    logic                   mark_q, mark_d;
`endif

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_valid),
        .wr_data (P_DATA),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign ready     = !fifo_full;
    assign TX_out    = tx_q;
    assign busy      = busy_q;
    assign period_m1 = (prescale_q == '0) ? '0 : prescale_q - 1'b1;
    assign bit_end   = (timer_q >= period_m1);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        pop        = 1'b0;
        cfg_ld     = 1'b0;
        frame_done = 1'b0;
`ifdef UART_TX_BREAK_EN
        mark_d     = mark_q;
`endif
        case (state_q)
            IDLE: frame_done = 1'b1;
            START: if (bit_end) begin
                state_d   = DATA;
                timer_d   = '0;
                bit_idx_d = '0;
                tx_d      = shift_q[0];
            end
            DATA: if (bit_end) begin
                timer_d = '0;
                if (bit_idx_q == IDX_W'(DATA_WIDTH-1)) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = LINE_IDLE;
                    end
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    shift_d   = shift_q >> 1;
                    tx_d      = shift_q[1];
                end
            end
            PARITY: if (bit_end) begin
                state_d    = STOP;
                timer_d    = '0;
                stop_idx_d = 1'b0;
                tx_d       = LINE_IDLE;
            end
            STOP: if (bit_end) begin
                timer_d = '0;
                if (stop2_q && !stop_idx_q) stop_idx_d = 1'b1;
                else                        frame_done = 1'b1;
            end
`ifdef UART_TX_BREAK_EN
            // Hold the line low while requested, then one bit period of mark.
            BREAK: begin
                if (mark_q) begin
                    if (bit_end) begin
                        state_d = IDLE;
                        timer_d = '0;
                        mark_d  = 1'b0;
                        tx_d    = LINE_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    timer_d = '0;
                    if (!send_break) begin
                        mark_d = 1'b1;
                        tx_d   = LINE_IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // End of frame (or idle): the next word pops in the same cycle, so no gap.
        if (frame_done) begin
            timer_d = '0;
`ifdef UART_TX_BREAK_EN
            if (send_break) begin
                state_d = BREAK;
                cfg_ld  = 1'b1;
                mark_d  = 1'b0;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
            end else
`endif
            if (!fifo_empty) begin
                state_d = START;
                pop     = 1'b1;
                cfg_ld  = 1'b1;
                shift_d = head;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                tx_d    = LINE_IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= LINE_IDLE;
            busy_q     <= 1'b0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            prescale_q <= '0;
`ifdef UART_TX_BREAK_EN
            mark_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_BREAK_EN
            mark_q     <= mark_d;
`endif
            if (cfg_ld) begin
                par_en_q   <= PAR_EN;
                stop2_q    <= STOP2;
                prescale_q <= Prescale;
                par_q      <= (^head) ^ (PAR_TYP == PAR_ODD);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: words queued at push, frames checked cycle by cycle on TX_out.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst_n;
    logic        PAR_EN, PAR_TYP, STOP2;
    logic [15:0] Prescale;
    logic [7:0]  P_DATA;
    logic        data_valid;
    logic        ready, tx_out, busy;
    logic [3:0]  fifo_count;
`ifdef UART_TX_BREAK_EN
    logic        send_break = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       stop2;
        int         p;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     fails  = 0;

    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .PRESCALE_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
`ifdef UART_TX_BREAK_EN
        .send_break (send_break),
`endif
        .ready      (ready),
        .TX_out     (tx_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Frame monitor: pops the scoreboard on each start bit and checks every cycle.
    frame_t      cur;
    logic [15:0] ebits;
    logic [7:0]  sdata;
    logic        spar;
    int          p_cur, nb, cyc, bad, bi;
    bit          mon_active = 0;
    bit          expect_b2b = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 0;
            expect_b2b = 0;
        end else begin
            if (!mon_active) begin
                if (expect_b2b) begin
                    chk("b2b_start", 32'(tx_out), 0);
                    chk("b2b_busy", 32'(busy), 1);
                    expect_b2b = 0;
                end
                if (tx_out === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexp_start", 32'(tx_out), 1);
                    end else begin
                        cur   = exp_q.pop_front();
                        p_cur = (cur.p == 0) ? 1 : cur.p;
                        ebits = '1;
                        ebits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) ebits[1+i] = cur.data[i];
                        nb = 9;
                        if (cur.par_en) begin
                            ebits[9] = (^cur.data) ^ cur.par_typ;
                            nb = 10;
                        end
                        nb = nb + (cur.stop2 ? 2 : 1);
                        sdata = 'x;
                        spar  = 1'bx;
                        cyc = 0;
                        bad = 0;
                        mon_active = 1;
                    end
                end
            end
            if (mon_active) begin
                bi = cyc / p_cur;
                if (tx_out !== ebits[bi] || busy !== 1'b1) bad++;
                if (cyc % p_cur == p_cur / 2) begin
                    if (bi >= 1 && bi <= 8) sdata[bi-1] = tx_out;
                    if (cur.par_en && bi == 9) spar = tx_out;
                end
                cyc++;
                if (cyc == nb * p_cur) begin
                    chk("frame_cycles", 32'(bad), 0);
                    chk("data", 32'(sdata), 32'(cur.data));
                    if (cur.par_en) chk("parity", 32'(spar), 32'((^cur.data) ^ cur.par_typ));
                    mon_active = 0;
                    expect_b2b = (exp_q.size() > 0);
                end
            end
        end
    end

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        P_DATA     = d;
        data_valid = 1'b1;
        exp_q.push_back('{d, PAR_EN, PAR_TYP, STOP2, int'(Prescale)});
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk("timeout", 1, 0);
        @(negedge clk);
        chk("idle_tx", 32'(tx_out), 1);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bad;
        rst_n = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        Prescale = 16'd4; P_DATA = '0; data_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx_out), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_count", 32'(fifo_count), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0xA5, latency of one edge to the start bit
        P_DATA = 8'hA5; data_valid = 1'b1;
        exp_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0, 4});
        @(negedge clk);
        data_valid = 1'b0;
        chk("lat_push_tx", 32'(tx_out), 1);
        chk("lat_push_cnt", 32'(fifo_count), 1);
        @(negedge clk);
        chk("lat_pop_tx", 32'(tx_out), 0);
        chk("lat_pop_busy", 32'(busy), 1);
        chk("lat_pop_cnt", 32'(fifo_count), 0);
        wait_idle(200);

        // Parity even/odd, then two stop bits
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        push(8'h07); wait_idle(200);
        PAR_TYP = 1'b1;
        push(8'h07); wait_idle(200);
        STOP2 = 1'b1;
        push(8'h07); wait_idle(200);
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;

        // Fill the FIFO while a frame is on the line; ninth push refused
        push(8'h10);
        for (int i = 0; i < 9; i++) begin
            P_DATA = 8'h20 + 8'(i);
            data_valid = 1'b1;
            if (i < 8) exp_q.push_back('{P_DATA, 1'b0, 1'b0, 1'b0, 4});
            else       chk("ready_full", 32'(ready), 0);
            @(negedge clk);
        end
        data_valid = 1'b0;
        chk("count_full", 32'(fifo_count), 8);
        wait_idle(3000);

        // Push on the exact pop cycle: count holds at 1
        Prescale = 16'd2;
        @(negedge clk);
        P_DATA = 8'h3C; data_valid = 1'b1;
        exp_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 2});
        @(negedge clk);
        P_DATA = 8'hC3;
        exp_q.push_back('{8'hC3, 1'b0, 1'b0, 1'b0, 2});
        @(negedge clk);
        data_valid = 1'b0;
        chk("cnt_pushpop", 32'(fifo_count), 1);
        wait_idle(200);

        // Prescale=0 acts as 1; PAR_EN change mid-frame is ignored
        Prescale = 16'd0;
        push(8'h3C);
        repeat (3) @(negedge clk);
        PAR_EN = 1'b1;
        wait_idle(100);
        push(8'h96);
        wait_idle(100);
        PAR_EN = 1'b0;

        // Reset during data bit 3
        Prescale = 16'd4;
        push(8'h5A);
        P_DATA = 8'h11; data_valid = 1'b1;
        exp_q.push_back('{8'h11, 1'b0, 1'b0, 1'b0, 4});
        @(negedge clk);
        data_valid = 1'b0;
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(tx_out), 1);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_cnt", 32'(fifo_count), 0);
        chk("rst_mid_ready", 32'(ready), 1);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        n_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) n_bad++;
        end
        chk("idle_after_rst", 32'(n_bad), 0);
        push(8'hE1);
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
